// File: rtl/morse_rx.sv
// morse_rx: Morse keyed-line receiver that times marks/spaces in units and decodes them to ASCII bytes
module morse_rx #(
  parameter int CLK_DIV = 4194304,
  parameter int DIV_W   = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       overrun
);
  typedef enum logic [1:0] {IDLE, MARK, GAP} state_t;
  state_t           r_state;
  logic             r_s1, r_ks, r_ks_d;
  logic [DIV_W-1:0] r_pre;
  logic [2:0]       r_unit, r_len;
  logic [4:0]       r_bits;
  logic             r_ovf, r_since;
  logic             w_rise, w_fall, w_edge, w_gap_live, w_emit_chr, w_emit_spc, w_emit;
  logic [7:0]       w_dec, w_char;
  assign w_rise     = r_ks & ~r_ks_d;
  assign w_fall     = ~r_ks & r_ks_d;
  assign w_edge     = w_rise | w_fall;
  assign w_gap_live = (r_state == GAP) && !w_rise;
  assign w_emit_chr = w_gap_live && r_unit >= 3'd2 && r_unit < 3'd5 && (r_len != 3'd0 || r_ovf);
  assign w_emit_spc = w_gap_live && r_unit >= 3'd5 && r_since;
  assign w_emit     = w_emit_chr | w_emit_spc;
  assign w_char     = w_emit_spc ? 8'h20 : w_dec;
  // two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_ks   <= 1'b0;
      r_ks_d <= 1'b0;
    end else begin
      r_s1   <= key;
      r_ks   <= r_s1;
      r_ks_d <= r_ks;
    end
  end
  // unit timer: half-unit preload on each edge makes unit_cnt round to the nearest unit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_unit <= 3'd0;
    end else if (w_edge) begin
      r_pre  <= DIV_W'(CLK_DIV / 2);
      r_unit <= 3'd0;
    end else if (r_pre == '0) begin
      r_pre  <= DIV_W'(CLK_DIV - 1);
      r_unit <= (r_unit == 3'd7) ? 3'd7 : r_unit + 3'd1;
    end else begin
      r_pre  <= r_pre - DIV_W'(1);
    end
  end
  // ITU table keyed on {length, symbols}; symbol 0 sits in bit 0, 1 = dash
  always_comb begin
    w_dec = 8'h3F;
    case ({r_len, r_bits})
      {3'd2, 5'b00010}: w_dec = 8'h41;
      {3'd4, 5'b00001}: w_dec = 8'h42;
      {3'd4, 5'b00101}: w_dec = 8'h43;
      {3'd3, 5'b00001}: w_dec = 8'h44;
      {3'd1, 5'b00000}: w_dec = 8'h45;
      {3'd4, 5'b00100}: w_dec = 8'h46;
      {3'd3, 5'b00011}: w_dec = 8'h47;
      {3'd4, 5'b00000}: w_dec = 8'h48;
      {3'd2, 5'b00000}: w_dec = 8'h49;
      {3'd4, 5'b01110}: w_dec = 8'h4A;
      {3'd3, 5'b00101}: w_dec = 8'h4B;
      {3'd4, 5'b00010}: w_dec = 8'h4C;
      {3'd2, 5'b00011}: w_dec = 8'h4D;
      {3'd2, 5'b00001}: w_dec = 8'h4E;
      {3'd3, 5'b00111}: w_dec = 8'h4F;
      {3'd4, 5'b00110}: w_dec = 8'h50;
      {3'd4, 5'b01011}: w_dec = 8'h51;
      {3'd3, 5'b00010}: w_dec = 8'h52;
      {3'd3, 5'b00000}: w_dec = 8'h53;
      {3'd1, 5'b00001}: w_dec = 8'h54;
      {3'd3, 5'b00100}: w_dec = 8'h55;
      {3'd4, 5'b01000}: w_dec = 8'h56;
      {3'd3, 5'b00110}: w_dec = 8'h57;
      {3'd4, 5'b01001}: w_dec = 8'h58;
      {3'd4, 5'b01101}: w_dec = 8'h59;
      {3'd4, 5'b00011}: w_dec = 8'h5A;
      {3'd5, 5'b11111}: w_dec = 8'h30;
      {3'd5, 5'b11110}: w_dec = 8'h31;
      {3'd5, 5'b11100}: w_dec = 8'h32;
      {3'd5, 5'b11000}: w_dec = 8'h33;
      {3'd5, 5'b10000}: w_dec = 8'h34;
      {3'd5, 5'b00000}: w_dec = 8'h35;
      {3'd5, 5'b00001}: w_dec = 8'h36;
      {3'd5, 5'b00011}: w_dec = 8'h37;
      {3'd5, 5'b00111}: w_dec = 8'h38;
      {3'd5, 5'b01111}: w_dec = 8'h39;
      default:          w_dec = 8'h3F;
    endcase
    if (r_ovf) w_dec = 8'h3F;
  end
  // receive FSM with symbol buffer and registered byte output / handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_len      <= 3'd0;
      r_bits     <= 5'd0;
      r_ovf      <= 1'b0;
      r_since    <= 1'b0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (w_emit) begin
        if (!data_valid || data_ready) begin
          data       <= w_char;
          data_valid <= 1'b1;
        end else begin
          overrun    <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      case (r_state)
        IDLE: if (w_rise) r_state <= MARK;
        MARK: if (w_fall) begin
          if (r_unit != 3'd0) begin
            if (r_len == 3'd5) begin
              r_ovf <= 1'b1;
            end else begin
              r_bits[r_len] <= (r_unit >= 3'd2);
              r_len         <= r_len + 3'd1;
            end
          end
          r_state <= GAP;
        end
        GAP: if (w_rise) begin
          r_state <= MARK;
        end else if (r_unit >= 3'd5) begin
          r_since <= 1'b0;
          r_state <= IDLE;
        end else if (w_emit_chr) begin
          r_len   <= 3'd0;
          r_bits  <= 5'd0;
          r_ovf   <= 1'b0;
          r_since <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_morse_rx.sv
// tb_morse_rx: scoreboard bench keying directed Morse patterns into morse_rx
module tb_morse_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key = 1'b0;
  logic       data_ready = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       overrun;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];

  morse_rx #(.CLK_DIV(8), .DIV_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .data(data),
    .data_valid(data_valid), .data_ready(data_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // monitor: every completed transfer must match the oldest expected byte
  always @(negedge clk) begin
    if (rst_n && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %h required none", data);
      end else begin
        check("rx_byte", data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mark(input int n);
    key = 1'b1;
    tick(n);
    key = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      mark(s[i] == 8'h2D ? 24 : 8);
      if (i < s.len() - 1) tick(8);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
    check(name, 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    tick(3);
    check("reset_data", data, 8'h00);
    check("reset_valid", {7'd0, data_valid}, 8'd0);
    check("reset_overrun", {7'd0, overrun}, 8'd0);
    rst_n = 1'b1;
    tick(4);
    // HELLO + word space at exact timing
    exp_q.push_back(8'h48); exp_q.push_back(8'h45); exp_q.push_back(8'h4C);
    exp_q.push_back(8'h4C); exp_q.push_back(8'h4F); exp_q.push_back(8'h20);
    send("...."); tick(24);
    send(".");    tick(24);
    send(".-.."); tick(24);
    send(".-.."); tick(24);
    send("---");  tick(64);
    drain("hello_drain");
    check("hello_overrun", {7'd0, overrun}, 8'd0);
    // ".-" with 3-cycle jitter on every mark and gap
    exp_q.push_back(8'h41); exp_q.push_back(8'h20);
    mark(11); tick(11); mark(21); tick(61);
    drain("jitter_drain");
    exp_q.push_back(8'h30); exp_q.push_back(8'h20);
    send("-----"); tick(64);
    drain("zero_drain");
    // six symbols and an unassigned four-symbol pattern both give '?'
    exp_q.push_back(8'h3F); exp_q.push_back(8'h20);
    send(".-.-.-"); tick(64);
    drain("six_sym_drain");
    exp_q.push_back(8'h3F); exp_q.push_back(8'h20);
    send("..--"); tick(64);
    drain("invalid_drain");
    // sink stalled: E is held, T and the following space are dropped
    data_ready = 1'b0;
    exp_q.push_back(8'h45);
    send("."); tick(24);
    check("stall_overrun_pre", {7'd0, overrun}, 8'd0);
    send("-"); tick(64);
    check("stall_valid", {7'd0, data_valid}, 8'd1);
    check("stall_data", data, 8'h45);
    check("stall_overrun", {7'd0, overrun}, 8'd1);
    data_ready = 1'b1;
    tick(3);
    check("stall_valid_after", {7'd0, data_valid}, 8'd0);
    drain("stall_drain");
    // glitch is ignored and leaves no partial symbol behind
    mark(3); tick(64);
    check("glitch_valid", {7'd0, data_valid}, 8'd0);
    exp_q.push_back(8'h45); exp_q.push_back(8'h20);
    send("."); tick(64);
    drain("glitch_drain");
    // reset in the middle of a dash
    key = 1'b1;
    tick(12);
    rst_n = 1'b0;
    #1;
    check("midrst_data", data, 8'h00);
    check("midrst_valid", {7'd0, data_valid}, 8'd0);
    check("midrst_overrun", {7'd0, overrun}, 8'd0);
    key = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    exp_q.push_back(8'h54); exp_q.push_back(8'h20);
    send("-"); tick(64);
    drain("midrst_drain");
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
